spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- Byte-wide serial shift engine with a parallel host-side load/read interface.
- A host strobe (wr or rd with cs low) starts one 8-bit full-duplex transfer.
- During the transfer the block drives sclk and shifts the byte MSB-first on miso, while sampling mosi.
- When the transfer ends, the received byte is presented on out_data.

Parameters:
- DATA_W, 8: transfer width in bits.
- SCLK_DIV, 1: clk cycles per sclk half-period; must be at least 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  byte to transmit; captured at transfer start.
- wr  input  1  write strobe; starts a transfer that transmits in_data.
- rd  input  1  read strobe; starts a receive-only transfer that transmits zeros.
- cs  input  1  active-low host select; wr and rd are ignored while cs=1.
- out_data  output  DATA_W  last received byte, registered.
- mosi  input  1  serial data in.
- miso  output  1  serial data out, MSB first.
- sclk  output  1  generated serial clock, idle low (mode 0).

Behaviour:
- Reset: asynchronous on rst_n=0, independent of clk.
  - State goes to IDLE.
  - sclk=0, miso=0, out_data=0, shift registers=0, divider and bit counters=0.
  - Reset mid-transfer aborts the transfer immediately; out_data is not updated.
- States:
  - IDLE: sclk=0, miso=0. A rising clk edge with cs=0 and (wr|rd)=1 starts a transfer.
    - If wr=1 (whether or not rd=1), tx_reg is loaded with in_data.
    - If only rd=1, tx_reg is loaded with 0.
    - In both cases rx_reg is cleared, bit_cnt is cleared, and the state goes to SHIFT.
  - SHIFT: miso is driven from tx_reg[DATA_W-1] continuously, so the MSB is valid from the cycle after the load.
    - Each half-period of SCLK_DIV clk cycles, sclk toggles.
    - On the 0->1 toggle (rising sclk): rx_reg is shifted left with mosi entering at the LSB.
    - On the 1->0 toggle (falling sclk): tx_reg is shifted left with a 0 fill, and bit_cnt is incremented.
    - After the DATA_W-th falling toggle, the state goes to DONE.
    - Total SHIFT duration is 2*DATA_W*SCLK_DIV clk cycles; this is 16 cycles at the defaults.
  - DONE: one cycle.
    - out_data is loaded from rx_reg, miso is driven to 0, and the state returns to IDLE.
    - A new start is accepted on the following edge at the earliest.
- Strobe handling:
  - wr and rd are level-sampled only in IDLE. A strobe held for several cycles starts exactly one transfer.
  - A strobe still held after DONE starts another transfer.
  - wr, rd, cs and in_data are ignored in SHIFT and DONE.
- cs only gates host strobes. The transfer continues when cs returns high.
- out_data holds its value between transfers; rd does not change it directly.
- sclk, miso and out_data are all registered outputs with no combinational paths from inputs.

Decomposition:
- Package spi_pkg:
  - state_t enum with IDLE, SHIFT, DONE.
  - DATA_W default constant.
- Optional sub-module spi_sclk_gen: SCLK_DIV half-period counter that emits rise_tick and fall_tick and drives sclk while enabled.
- Everything else stays in spi_slave.

Test Plan:
- Reset: hold rst_n=0 with wr=1 and cs=0 -> sclk=0, miso=0 and out_data=0x00 throughout; no transfer starts until rst_n=1.
- Write 0xBB with mosi=0 -> exactly 8 sclk pulses in 16 clk cycles.
  - miso at each sclk rise is 1,0,1,1,1,0,1,1.
  - out_data=0x00 one cycle after the 8th fall.
- Loopback (mosi tied to miso), write 0xA5 -> out_data=0xA5 at DONE.
- Back-to-back writes of 0xFF, 0x22 and 0x33, spaced 19 cycles apart -> miso patterns match each byte and no sclk pulses are lost.
- rd only with cs=0 and mosi driving 0x3C MSB-first on sclk rises -> miso stays 0 and out_data=0x3C.
- Ignored strobes:
  - wr=1 with cs=1 in IDLE -> no sclk activity.
  - wr=1 with cs=0 and in_data=0x11 mid-SHIFT of 0xBB -> 0xBB pattern unchanged.
  - rst_n pulse mid-SHIFT -> sclk=0 immediately and out_data unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the byte-wide SPI shift engine.
`timescale 1ns/1ps
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: toggles sclk every SCLK_DIV clk cycles while enabled, idle low.
`timescale 1ns/1ps
module spi_sclk_gen #(
  parameter int SCLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick      = en && (div_cnt == '0);
  assign rise_tick = tick && !sclk;
  assign fall_tick = tick && sclk;

  // Reloaded while disabled so the first half-period is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= DIV_W'(SCLK_DIV - 1);
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= DIV_W'(SCLK_DIV - 1);
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// Byte-wide full-duplex shift engine: host strobe loads a byte, shifts it MSB-first on miso
// while sampling mosi, then presents the received byte on out_data.
//   state | meaning
//   IDLE  | sclk low, waiting for cs=0 with wr or rd
//   SHIFT | sclk running, rx on rising sclk, tx on falling sclk
//   DONE  | one cycle, out_data takes rx_reg
`timescale 1ns/1ps
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SCLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr,
  input  logic              rd,
  input  logic              cs,
  output logic [DATA_W-1:0] out_data,
  input  logic              mosi,
  output logic              miso,
  output logic              sclk
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tx_reg, rx_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              start, rise_tick, fall_tick, last_fall;

  assign start     = !cs && (wr || rd);
  assign last_fall = fall_tick && (bit_cnt == CNT_W'(DATA_W - 1));
  // tx_reg is zero outside SHIFT, so miso idles low without extra gating.
  assign miso      = tx_reg[DATA_W-1];

  spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == SHIFT),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg   <= '0;
      rx_reg   <= '0;
      bit_cnt  <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx_reg  <= wr ? in_data : '0;
            rx_reg  <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (rise_tick) rx_reg <= {rx_reg[DATA_W-2:0], mosi};
          if (fall_tick) begin
            tx_reg  <= {tx_reg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          out_data <= rx_reg;
          tx_reg   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave at DATA_W=8, SCLK_DIV=1.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       cs = 1'b1;
  logic [7:0] out_data;
  logic       mosi;
  logic       miso;
  logic       sclk;

  logic       loopback = 1'b0;
  logic       mosi_drv = 1'b0;
  logic [7:0] mosi_byte = 8'h00;
  logic [7:0] miso_cap = 8'h00;
  logic       miso_seen = 1'b0;
  int         rise_cnt = 0;
  int         fall_cnt = 0;
  int         rise_base = 0;
  int         fall_base = 0;
  int         checks = 0;
  int         errors = 0;

  assign mosi = loopback ? miso : mosi_drv;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .wr       (wr),
    .rd       (rd),
    .cs       (cs),
    .out_data (out_data),
    .mosi     (mosi),
    .miso     (miso),
    .sclk     (sclk)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rise_cnt = rise_cnt + 1;
    miso_cap = {miso_cap[6:0], miso};
  end

  always @(negedge sclk) fall_cnt = fall_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k = rise_cnt - rise_base;
      mosi_drv = (k < 8) ? mosi_byte[7-k] : 1'b0;
      if (miso !== 1'b0) miso_seen = 1'b1;
    end
  endtask

  task automatic start(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b0; wr = w; rd = r; in_data = d;
    rise_base = rise_cnt; fall_base = fall_cnt;
    mosi_drv = mosi_byte[7];
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; rd = 1'b0; in_data = 8'h00;
  endtask

  initial begin
    logic [7:0] b2b [3];
    b2b[0] = 8'hFF; b2b[1] = 8'h22; b2b[2] = 8'h33;

    // reset held with an active write request
    cs = 1'b0; wr = 1'b1; in_data = 8'hBB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_outputs", {sclk, miso, out_data}, 10'h000);
    end
    chk("rst_no_sclk", rise_cnt, 0);

    // write 0xBB starts on the first edge after release
    rise_base = rise_cnt; fall_base = fall_cnt;
    rst_n = 1'b1;
    @(negedge clk);
    wr = 1'b0; cs = 1'b1;
    chk("bb_msb_early", miso, 1'b1);
    run(15);
    chk("bb_sclk_high_c15", sclk, 1'b1);
    run(1);
    chk("bb_rises", rise_cnt - rise_base, 8);
    chk("bb_falls", fall_cnt - fall_base, 8);
    chk("bb_miso_pattern", miso_cap, 8'hBB);
    run(1);
    chk("bb_out_data", out_data, 8'h00);
    run(3);
    chk("bb_no_extra", rise_cnt - rise_base, 8);

    // loopback 0xA5
    loopback = 1'b1;
    start(1'b1, 1'b0, 8'hA5);
    run(16);
    chk("a5_miso_pattern", miso_cap, 8'hA5);
    run(1);
    chk("a5_out_data", out_data, 8'hA5);
    run(1);

    // back-to-back writes, 19 cycles apart, loopback
    for (int t = 0; t < 3; t++) begin
      start(1'b1, 1'b0, b2b[t]);
      run(16);
      chk("b2b_rises", rise_cnt - rise_base, 8);
      chk("b2b_miso_pattern", miso_cap, b2b[t]);
      run(1);
      chk("b2b_out_data", out_data, b2b[t]);
    end
    loopback = 1'b0;
    run(1);

    // read-only with mosi carrying 0x3C
    mosi_byte = 8'h3C;
    miso_seen = 1'b0;
    start(1'b0, 1'b1, 8'hFF);
    run(16);
    chk("rd_miso_zero", {miso_seen, miso_cap}, 9'h000);
    chk("rd_rises", rise_cnt - rise_base, 8);
    run(1);
    chk("rd_out_data", out_data, 8'h3C);
    mosi_byte = 8'h00;
    run(1);

    // write with cs high is ignored
    rise_base = rise_cnt;
    cs = 1'b1; wr = 1'b1; in_data = 8'h77;
    run(5);
    chk("cs_high_no_sclk", rise_cnt - rise_base, 0);
    chk("cs_high_sclk_low", sclk, 1'b0);
    chk("cs_high_out_hold", out_data, 8'h3C);
    wr = 1'b0;

    // strobe mid-SHIFT is ignored
    start(1'b1, 1'b0, 8'hBB);
    run(5);
    cs = 1'b0; wr = 1'b1; in_data = 8'h11;
    run(3);
    cs = 1'b1; wr = 1'b0; in_data = 8'h00;
    run(8);
    chk("mid_rises", rise_cnt - rise_base, 8);
    chk("mid_miso_pattern", miso_cap, 8'hBB);
    run(1);
    chk("mid_out_data", out_data, 8'h00);
    run(1);

    // reset pulse mid-SHIFT aborts immediately
    loopback = 1'b1;
    start(1'b1, 1'b0, 8'h5A);
    run(5);
    chk("abort_pre_sclk", sclk, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("abort_sclk_miso", {sclk, miso}, 2'b00);
    chk("abort_out_data", out_data, 8'h00);
    #1 rst_n = 1'b1;
    rise_base = rise_cnt;
    run(20);
    chk("abort_no_resume", rise_cnt - rise_base, 0);
    chk("abort_out_hold", out_data, 8'h00);
    loopback = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
